flyer_sprite: RTL and testbench

//  Player-sprite stage downstream of the 640x360 VGA timing generator. Consumes pixel

---
 rtl/flyer_pkg.sv | 24 ++
 rtl/flyer_sprite_btn_sync_edge.sv | 31 +++
 rtl/flyer_sprite.sv | 219 +++++++++++++++++++++
 tb/tb_flyer_sprite.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/flyer_pkg.sv
// Shared definitions for the flyer sprite stage: FSM state encoding,
// fixed-point layout of the vertical position and colour width.
package flyer_pkg;

  // Position is 9.4 unsigned fixed point; velocity is signed 1/16 px per frame.
  localparam int FRAC   = 4;
  localparam int INT_W  = 9;
  localparam int POS_W  = INT_W + FRAC;
  localparam int VEL_W  = 8;
  localparam int RGB_W  = 12;

  // Encoding is visible on o_state, so it is pinned explicitly.
  typedef enum logic [1:0] {
    ST_READY   = 2'b00,
    ST_FLYING  = 2'b01,
    ST_CRASHED = 2'b10
  } state_t;

  // Convert an integer pixel row into the fixed-point position format.
  function automatic logic [POS_W-1:0] px_to_pos(input int px);
    return POS_W'(px << FRAC);
  endfunction

endpackage

// File: rtl/flyer_sprite_btn_sync_edge.sv
// btn_sync_edge: brings an asynchronous button into the i_clk domain through
// two flops and emits a one-cycle pulse on each synchronised rising edge.
module btn_sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Synchroniser chain plus a delayed copy for edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make each flop sample the old value of
      // its predecessor, which is what turns this into a real 3-stage chain.
      r_meta <= i_btn;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/flyer_sprite.sv
// flyer_sprite: player sprite stage behind the 640x360 timing generator.
// Runs per-frame vertical physics (gravity, flap impulse, crash handling) on
// i_animate and produces a registered per-pixel hit and colour.
// Optional build macro: CRASH_FLASH_EN -- blink the sprite while CRASHED.
module flyer_sprite
  import flyer_pkg::*;
#(
  parameter int                X_POS      = 100,
  parameter int                SIZE       = 16,
  parameter int                SCREEN_H   = 360,
  parameter int                Y_START    = 172,
  parameter int                GRAVITY    = 2,
  parameter int                FLAP_VEL   = -40,
  parameter int                VMAX       = 64,
  parameter int                CRASH_HOLD = 60,
  parameter logic [RGB_W-1:0]  COLOUR     = 12'hFF0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_pix_stb,
  input  logic [9:0]       i_x,
  input  logic [8:0]       i_y,
  input  logic             i_active,
  input  logic             i_animate,
  input  logic             i_flap,
  input  logic             i_collide,
  output logic             o_draw,
  output logic [RGB_W-1:0] o_rgb,
  output logic [1:0]       o_state,
  output logic [8:0]       o_y_pos
);

  localparam int HOLD_W = $clog2(CRASH_HOLD + 1);

  localparam logic [POS_W-1:0]        START_POS  = px_to_pos(Y_START);
  localparam logic [POS_W-1:0]        FLOOR_POS  = px_to_pos(SCREEN_H - SIZE);
  localparam logic [POS_W-1:0]        FLAP_DELTA = POS_W'(FLAP_VEL);
  localparam logic signed [VEL_W-1:0] FLAP_V     = VEL_W'(FLAP_VEL);
  localparam logic signed [VEL_W-1:0] VMAX_V     = VEL_W'(VMAX);
  localparam logic signed [VEL_W:0]   VMAX_W     = (VEL_W + 1)'(VMAX);
  localparam logic signed [VEL_W:0]   GRAV_W     = (VEL_W + 1)'(GRAVITY);
  localparam logic [10:0]             SIZE_11    = 11'(SIZE);
  localparam logic [10:0]             SCREEN_11  = 11'(SCREEN_H);
  localparam logic [9:0]              X_POS_10   = 10'(X_POS);
  localparam logic [9:0]              SIZE_10    = 10'(SIZE);
  localparam logic [8:0]              SIZE_9     = 9'(SIZE);
  localparam logic [HOLD_W-1:0]       HOLD_MAX   = HOLD_W'(CRASH_HOLD);

  // ---------------------------------------------------------------------------
  // Flap input: synchronise, edge-detect, latch until the next frame tick.
  // ---------------------------------------------------------------------------
  logic w_flap_rise;
  logic w_flap;
  logic r_flap_pend;

  btn_sync_edge u_flap_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_btn   (i_flap),
    .o_rise  (w_flap_rise)
  );

  // An edge landing on the animate cycle itself still counts for that frame.
  assign w_flap = r_flap_pend | w_flap_rise;

  // Pending flap: set by an edge, consumed by every frame tick.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_flap_pend <= 1'b0;
    end else if (i_animate) begin
      r_flap_pend <= 1'b0;
    end else if (w_flap_rise) begin
      r_flap_pend <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Physics FSM
  // ---------------------------------------------------------------------------
  state_t                    r_state, w_state_n;
  logic [POS_W-1:0]          r_pos, w_pos_n;
  logic signed [VEL_W-1:0]   r_vel, w_vel_n;
  logic [HOLD_W-1:0]         r_hold, w_hold_n;

  logic signed [VEL_W:0]     w_vel_grav;
  logic signed [VEL_W-1:0]   w_vel_fall;
  logic signed [VEL_W-1:0]   w_vel_fly;
  logic signed [POS_W:0]     w_p;
  logic [10:0]               w_p_bottom;

  // Candidate flying velocity and position for this frame.
  assign w_vel_grav = {r_vel[VEL_W-1], r_vel} + GRAV_W;
  assign w_vel_fall = (w_vel_grav > VMAX_W) ? VMAX_V : w_vel_grav[VEL_W-1:0];
  assign w_vel_fly  = w_flap ? FLAP_V : w_vel_fall;
  assign w_p        = $signed({1'b0, r_pos})
                    + $signed({{(POS_W + 1 - VEL_W){w_vel_fly[VEL_W-1]}}, w_vel_fly});
  assign w_p_bottom = {1'b0, w_p[POS_W:FRAC]} + SIZE_11;

  // State and physics registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_READY;
      r_pos   <= START_POS;
      r_vel   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_n;
      r_pos   <= w_pos_n;
      r_vel   <= w_vel_n;
      r_hold  <= w_hold_n;
    end
  end

  // Next-state and physics update, active only on the frame tick.
  always_comb begin
    // NOTE: every target gets a hold-value default first so no path through
    // the case statement leaves one unassigned and infers a latch.
    w_state_n = r_state;
    w_pos_n   = r_pos;
    w_vel_n   = r_vel;
    w_hold_n  = r_hold;
    if (i_animate) begin
      unique case (r_state)
        ST_READY: begin
          if (w_flap) begin
            w_state_n = ST_FLYING;
            w_vel_n   = FLAP_V;
            w_pos_n   = r_pos + FLAP_DELTA;
          end
        end
        ST_FLYING: begin
          if (w_p[POS_W]) begin
            w_pos_n   = '0;
            w_vel_n   = '0;
            w_state_n = ST_CRASHED;
          end else if (w_p_bottom > SCREEN_11) begin
            w_pos_n   = FLOOR_POS;
            w_vel_n   = '0;
            w_state_n = ST_CRASHED;
          end else if (i_collide) begin
            w_pos_n   = w_p[POS_W-1:0];
            w_vel_n   = '0;
            w_state_n = ST_CRASHED;
          end else begin
            w_pos_n   = w_p[POS_W-1:0];
            w_vel_n   = w_vel_fly;
          end
        end
        ST_CRASHED: begin
          w_vel_n = '0;
          if (r_hold == HOLD_MAX) begin
            if (w_flap) begin
              w_state_n = ST_READY;
              w_pos_n   = START_POS;
              w_hold_n  = '0;
            end
          end else begin
            w_hold_n = r_hold + 1'b1;
          end
        end
        default: begin
          w_state_n = ST_READY;
          w_pos_n   = START_POS;
          w_vel_n   = '0;
          w_hold_n  = '0;
        end
      endcase
    end
  end

  assign o_state = r_state;
  assign o_y_pos = r_pos[POS_W-1:FRAC];

  // ---------------------------------------------------------------------------
  // Optional crash blink
  // ---------------------------------------------------------------------------
  logic w_show;

`ifdef CRASH_FLASH_EN
  logic [3:0] r_frame_cnt;

  // Free-running frame counter; bit 3 toggles every 8 frames.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frame_cnt <= '0;
    end else if (i_animate) begin
      r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  assign w_show = !((r_state == ST_CRASHED) && r_frame_cnt[3]);
`else
  assign w_show = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Pixel path
  // ---------------------------------------------------------------------------
  logic [9:0] w_dx;
  logic [8:0] w_dy;
  logic       w_hit;

  // Wrapping subtraction folds the two-sided range test into one compare.
  assign w_dx  = i_x - X_POS_10;
  assign w_dy  = i_y - o_y_pos;
  assign w_hit = i_active & (w_dx < SIZE_10) & (w_dy < SIZE_9) & w_show;

  // Registered hit and colour, updated once per pixel strobe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_draw <= 1'b0;
      o_rgb  <= '0;
    end else if (i_pix_stb) begin
      o_draw <= w_hit;
      o_rgb  <= w_hit ? COLOUR : '0;
    end
  end

endmodule

// File: tb/tb_flyer_sprite.sv
// Self-checking bench for flyer_sprite: directed scenarios followed by random
// frames, all compared against a frame-level behavioural model.
module tb_flyer_sprite;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_stb = 1'b0;
  logic [9:0]  x = '0;
  logic [8:0]  y = '0;
  logic        active = 1'b0;
  logic        animate = 1'b0;
  logic        flap = 1'b0;
  logic        collide = 1'b0;
  logic        o_draw;
  logic [11:0] o_rgb;
  logic [1:0]  o_state;
  logic [8:0]  o_y_pos;

  flyer_sprite dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_pix_stb (pix_stb),
    .i_x       (x),
    .i_y       (y),
    .i_active  (active),
    .i_animate (animate),
    .i_flap    (flap),
    .i_collide (collide),
    .o_draw    (o_draw),
    .o_rgb     (o_rgb),
    .o_state   (o_state),
    .o_y_pos   (o_y_pos)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model (whole pixels / 1/16 px integers) -------
  localparam int M_READY = 0, M_FLYING = 1, M_CRASHED = 2;
  int m_state, m_pos, m_vel, m_hold;

  task automatic model_reset();
    m_state = M_READY; m_pos = 172 * 16; m_vel = 0; m_hold = 0;
  endtask

  task automatic model_frame(input bit fl, input bit col);
    int nv, p;
    case (m_state)
      M_READY: if (fl) begin
        m_state = M_FLYING; m_vel = -40; m_pos = m_pos - 40;
      end
      M_FLYING: begin
        nv = fl ? -40 : ((m_vel + 2 > 64) ? 64 : m_vel + 2);
        p  = m_pos + nv;
        if (p < 0) begin
          m_pos = 0; m_vel = 0; m_state = M_CRASHED;
        end else if (p / 16 + 16 > 360) begin
          m_pos = 344 * 16; m_vel = 0; m_state = M_CRASHED;
        end else if (col) begin
          m_pos = p; m_vel = 0; m_state = M_CRASHED;
        end else begin
          m_pos = p; m_vel = nv;
        end
      end
      default: begin
        m_vel = 0;
        if (m_hold == 60) begin
          if (fl) begin m_state = M_READY; m_pos = 172 * 16; m_hold = 0; end
        end else m_hold++;
      end
    endcase
  endtask

  // ---------------- stimulus helpers ----------------------------------------
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One frame: optional separated flap pulses, optional flap whose edge lands
  // exactly on the animate cycle, then the animate strobe and a state check.
  task automatic frame(input string tag, input int n_flaps, input bit col, input bit same);
    repeat ($urandom_range(1, 3)) @(negedge clk);
    for (int k = 0; k < n_flaps; k++) begin
      @(negedge clk) flap = 1'b1;
      repeat (2) @(negedge clk);
      flap = 1'b0;
      repeat (3) @(negedge clk);
    end
    if (same) begin
      @(negedge clk) flap = 1'b1;
      @(negedge clk);
    end
    @(negedge clk) begin animate = 1'b1; collide = col; end
    @(negedge clk) begin animate = 1'b0; collide = 1'b0; flap = 1'b0; end
    model_frame((n_flaps > 0) || same, col);
    check({tag, "_state"}, o_state, m_state);
    check({tag, "_ypos"}, o_y_pos, m_pos / 16);
  endtask

  function automatic bit exp_hit(input int px, input int py, input bit act);
    int top = m_pos / 16;
    return act && px >= 100 && px < 116 && py >= top && py < top + 16;
  endfunction

  task automatic probe(input string tag, input int px, input int py, input bit act);
    bit e;
    @(negedge clk) begin
      x = 10'(px); y = 9'(py); active = act; pix_stb = 1'b1;
    end
    @(negedge clk) pix_stb = 1'b0;
    e = exp_hit(int'(x), int'(y), act);
    check({tag, "_draw"}, o_draw, e);
    check({tag, "_rgb"}, o_rgb, e ? 'hFF0 : 0);
  endtask

  // ---------------- test sequence -------------------------------------------
  initial begin
    int top, guard;
    bit e;

    do_reset();
    check("rst_state", o_state, 0);
    check("rst_ypos", o_y_pos, 172);
    check("rst_draw", o_draw, 0);
    check("rst_rgb", o_rgb, 0);

    // Pixel compare around the READY sprite, including the edges.
    probe("pix_in", 100, 172, 1);
    check("pix_in_const", o_draw, 1);
    probe("pix_corner", 115, 187, 1);
    probe("pix_right", 116, 172, 1);
    probe("pix_below", 99, 188, 1);
    probe("pix_left", 99, 180, 1);
    probe("pix_blank", 100, 172, 0);
    probe("pix_on2", 107, 180, 1);
    // Output holds when inputs move but no strobe arrives.
    @(negedge clk) begin x = 10'd500; y = 9'd10; active = 1'b1; end
    @(negedge clk);
    check("pix_hold", o_draw, 1);

    // First flap and one gravity frame.
    frame("flap1", 1, 1'b0, 1'b0);
    check("flap1_y169", o_y_pos, 169);
    frame("grav1", 0, 1'b0, 1'b0);
    check("grav1_y167", o_y_pos, 167);

    // Flap edge coincident with animate, then two edges in one frame.
    frame("same_cyc", 0, 1'b0, 1'b1);
    frame("dbl_flap", 2, 1'b0, 1'b0);
    frame("after_dbl", 0, 1'b0, 1'b0);

    // Asynchronous reset while flying, with the sprite drawn beforehand.
    top = m_pos / 16;
    probe("pre_rst", 104, top + 2, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    model_reset();
    check("arst_state", o_state, 0);
    check("arst_ypos", o_y_pos, 172);
    check("arst_draw", o_draw, 0);

    // Free fall to the floor.
    frame("fall_start", 1, 1'b0, 1'b0);
    guard = 0;
    while (m_state != M_CRASHED && guard < 200) begin
      frame("fall", 0, 1'b0, 1'b0);
      guard++;
    end
    check("floor_ypos", o_y_pos, 344);
    check("floor_state", o_state, 2);

    // Crash hold: early flap discarded, flap at frame 61 accepted.
    for (int f = 1; f <= 61; f++) begin
      frame("hold", (f == 30 || f == 61) ? 1 : 0, 1'b0, 1'b0);
      if (f == 30) check("hold_f30_state", o_state, 2);
    end
    check("hold_f61_state", o_state, 0);
    check("hold_f61_ypos", o_y_pos, 172);

    // Ceiling crash by flapping every frame.
    guard = 0;
    while (m_state != M_CRASHED && guard < 120) begin
      frame("climb", 1, 1'b0, 1'b0);
      guard++;
    end
    check("ceil_ypos", o_y_pos, 0);
    check("ceil_state", o_state, 2);

    // Obstacle collision from mid-flight.
    do_reset();
    frame("col_fly", 1, 1'b0, 1'b0);
    frame("col_hit", 0, 1'b1, 1'b0);
    check("col_state", o_state, 2);

    // Random frames with random flaps, collisions and pixel probes.
    for (int f = 0; f < 400; f++) begin
      frame("rnd", ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0,
            $urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0);
      if (m_state != M_CRASHED) begin
        for (int k = 0; k < 2; k++) begin
          top = m_pos / 16;
          probe("rnd_pix", int'($urandom_range(92, 123)),
                (top + int'($urandom_range(0, 24)) - 4 + 512) % 512,
                $urandom_range(0, 3) != 0);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
